// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receive and transmit paths.
// - rx_state_t : receive FSM state encoding.
// - DEF_*      : default frame format, baud divisor and FIFO size. The TX
//                side and its baud generator use the same defaults.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int DEF_DBIT    = 8;    // data bits per frame, LSB first
    localparam int DEF_SB_TICK = 16;   // oversampling ticks in the stop bit
    localparam int DEF_DVSR    = 163;  // 50 MHz / (16 * 19200)
    localparam int DEF_FIFO_W  = 2;    // log2 of receive FIFO depth

endpackage

// File: rtl/rx_fifo.sv
// -----------------------------------------------------------------------------
// rx_fifo
// First-word-fall-through FIFO, DBIT wide and 2**FIFO_W deep. The head word is
// presented combinationally on data_out from registered state.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset; empties the FIFO
//   push     in   write data_in (ignored while full unless pop is effective)
//   data_in  in   word to write
//   pop      in   remove the head word (ignored while empty)
//   data_out out  head word, meaningful only while empty = 0
//   empty    out  no word stored
//   full     out  all 2**FIFO_W entries in use
// -----------------------------------------------------------------------------
module rx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT   = DEF_DBIT,
    parameter int FIFO_W = DEF_FIFO_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [DBIT-1:0] data_in,
    input  logic            pop,
    output logic [DBIT-1:0] data_out,
    output logic            empty,
    output logic            full
);

    localparam int DEPTH = 1 << FIFO_W;

    logic [DBIT-1:0]   mem [DEPTH];
    logic [FIFO_W-1:0] wr_ptr;
    logic [FIFO_W-1:0] rd_ptr;
    logic [FIFO_W-1:0] wr_ptr_next;
    logic [FIFO_W-1:0] rd_ptr_next;
    logic              empty_reg;
    logic              full_reg;
    logic              do_push;
    logic              do_pop;

    // A pop only counts when there is something to pop. A push into a full
    // FIFO is accepted only when the same edge frees a slot.
    assign do_pop      = pop & ~empty_reg;
    assign do_push     = push & (~full_reg | do_pop);
    assign wr_ptr_next = wr_ptr + 1'b1;   // wraps modulo depth
    assign rd_ptr_next = rd_ptr + 1'b1;

    // NOTE: sequential state is written with non-blocking (<=) assignments so
    // every flop samples pre-edge values regardless of statement order.
    // NOTE: the storage array is reset on purpose: r_data must read 0 after
    // reset, and at this depth a flop array costs nothing extra to clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    wr_ptr    <= wr_ptr_next;
                    empty_reg <= 1'b0;
                    full_reg  <= (wr_ptr_next == rd_ptr);
                end
                2'b01: begin
                    rd_ptr    <= rd_ptr_next;
                    full_reg  <= 1'b0;
                    empty_reg <= (rd_ptr_next == wr_ptr);
                end
                2'b11: begin
                    // Occupancy unchanged, so both flags hold.
                    wr_ptr <= wr_ptr_next;
                    rd_ptr <= rd_ptr_next;
                end
                default: ;
            endcase
        end
    end

    assign data_out = mem[rd_ptr];
    assign empty    = empty_reg;
    assign full     = full_reg;

endmodule

// File: rtl/uart_rx_buffered.sv
// -----------------------------------------------------------------------------
// uart_rx_buffered
// 8N1 serial receiver with 16x oversampling feeding a small FWFT FIFO. Frame
// errors and overruns are reported as one-cycle pulses; the affected byte is
// discarded.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   rx         in   serial input, idle high, asynchronous to clk
//   rd_uart    in   pop request; one byte removed per cycle while non-empty
//   rx_empty   out  FIFO holds no byte
//   r_data     out  FIFO head byte, valid while rx_empty = 0
//   frame_err  out  pulse: stop bit sampled low, byte discarded
//   overrun    out  pulse: byte arrived with FIFO full and no pop, byte dropped
// -----------------------------------------------------------------------------
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int DVSR    = DEF_DVSR,
    parameter int FIFO_W  = DEF_FIFO_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            rd_uart,
    output logic            rx_empty,
    output logic [DBIT-1:0] r_data,
    output logic            frame_err,
    output logic            overrun
);

    localparam int CNT_W = $clog2(DVSR);
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DVSR - 1);
    localparam logic [3:0]       S_MID     = 4'd7;   // middle of the start bit
    localparam logic [3:0]       S_BIT_END = 4'd15;  // middle of a data bit
    localparam logic [3:0]       S_STOP    = 4'(SB_TICK - 1);
    localparam logic [N_W-1:0]   N_LAST    = N_W'(DBIT - 1);

    // ---------------------------------------------------------------- sync
    logic rx_meta;
    logic rx_s;

    // Both stages reset to the idle level so reset release never looks like
    // a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ---------------------------------------------------------------- tick
    // Free-running; frames are not aligned to it, hence the +/-1 tick jitter
    // on sample points.
    logic [CNT_W-1:0] cnt;
    logic             tick;

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------- FSM
    rx_state_t       state, state_next;
    logic [3:0]      s, s_next;
    logic [N_W-1:0]  n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic            push;
    logic            ferr_next;
    logic            fifo_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
        end else begin
            state <= state_next;
            s     <= s_next;
            n     <= n_next;
            b     <= b_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        push       = 1'b0;
        ferr_next  = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s == S_MID) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            // Line went back high before mid-bit: a glitch.
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == S_BIT_END) begin
                        s_next = '0;
                        b_next = {rx_s, b[DBIT-1:1]};   // LSB arrives first
                        if (n == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n + 1'b1;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s == S_STOP) begin
                        state_next = IDLE;
                        if (rx_s) begin
                            push = 1'b1;
                        end else begin
                            ferr_next = 1'b1;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // --------------------------------------------------------- error pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_next;
            // A simultaneous pop frees the slot, so that case is not an overrun.
            overrun   <= push & fifo_full & ~rd_uart;
        end
    end

    // ---------------------------------------------------------------- FIFO
    rx_fifo #(
        .DBIT   (DBIT),
        .FIFO_W (FIFO_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .data_in  (b),
        .pop      (rd_uart),
        .data_out (r_data),
        .empty    (rx_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_buffered
// Drives 8N1 frames into uart_rx_buffered (DVSR = 4, 64 clk per bit) and
// compares every cycle against a byte-level model: a queue of stored bytes,
// plus a schedule of when each frame's stop bit is sampled. That instant
// follows from the timing rules: 2 clk of synchronizer delay, one clk to leave
// IDLE, then the 8th tick (start mid-bit), 16 ticks per data bit and SB_TICK
// ticks of stop bit, where ticks fall on cycles (cycle mod DVSR) = DVSR-1
// counted from reset release.
// -----------------------------------------------------------------------------
module tb_uart_rx_buffered;

    localparam int DBIT      = 8;
    localparam int SB_TICK   = 16;
    localparam int DVSR      = 4;
    localparam int FIFO_W    = 2;
    localparam int DEPTH     = 1 << FIFO_W;
    localparam int BIT_CLK   = 16 * DVSR;
    localparam int FRAME_CLK = (DBIT + 2) * BIT_CLK;
    localparam int STOP_LOW  = 40;   // low length of a bad stop bit (clk)

    logic            clk     = 1'b0;
    logic            reset   = 1'b0;
    logic            rx      = 1'b1;
    logic            rd_uart = 1'b0;
    logic            rx_empty;
    logic [DBIT-1:0] r_data;
    logic            frame_err;
    logic            overrun;

    uart_rx_buffered #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK),
        .DVSR    (DVSR),
        .FIFO_W  (FIFO_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_uart   (rd_uart),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------- model
    typedef struct {
        int              at;     // cycle whose closing edge samples the stop bit
        logic [DBIT-1:0] data;
        bit              ok;     // stop bit high
    } rx_event_t;

    rx_event_t       evq[$];
    logic [DBIT-1:0] q[$];
    int              cyc;
    bit              exp_ferr;
    bit              exp_ovr;
    bit              rand_pop;
    int              ferr_seen;
    int              ovr_seen;
    int              checks;
    int              errors;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock: update the model at the edge, compare at the falling edge.
    task automatic cycle();
        bit        full_before;
        rx_event_t ev;
        @(posedge clk);
        if (reset) begin
            cyc      = 0;
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
        end else begin
            full_before = (q.size() == DEPTH);
            exp_ferr    = 1'b0;
            exp_ovr     = 1'b0;
            if (rd_uart && q.size() != 0) void'(q.pop_front());
            if (evq.size() != 0 && evq[0].at == cyc) begin
                ev = evq.pop_front();
                if (!ev.ok)                      exp_ferr = 1'b1;
                else if (full_before && !rd_uart) exp_ovr = 1'b1;
                else                             q.push_back(ev.data);
            end
            cyc++;
        end
        @(negedge clk);
        if (!reset) begin
            check("rx_empty", rx_empty, (q.size() == 0));
            if (q.size() != 0) check("r_data", r_data, q[0]);
            check("frame_err", frame_err, exp_ferr);
            check("overrun", overrun, exp_ovr);
            if (frame_err) ferr_seen++;
            if (overrun)   ovr_seen++;
        end
    endtask

    // --------------------------------------------------------- stimulus
    task automatic drive_pop();
        if (rand_pop) rd_uart = ($urandom_range(0, 7) == 0);
        else          rd_uart = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rx = 1'b1;
            drive_pop();
            cycle();
        end
        rd_uart = 1'b0;
    endtask

    task automatic pop_one();
        rx      = 1'b1;
        rd_uart = 1'b1;
        cycle();
        rd_uart = 1'b0;
    endtask

    // abort_at >= 0 stops driving after that many clk and schedules nothing.
    task automatic send_frame(input logic [DBIT-1:0] d, input bit stop_ok,
                              input bit pop_at_stop, input int abort_at);
        int                k;
        int                t1;
        int                p;
        int                bi;
        logic [DBIT+1:0]   bits;
        k  = cyc;
        t1 = k + 3;                          // first START cycle
        while ((t1 % DVSR) != DVSR - 1) t1++;
        p  = t1 + (8 + 16 * DBIT + SB_TICK - 1) * DVSR;
        if (abort_at < 0) evq.push_back('{p, d, stop_ok});
        bits = {1'b1, d, 1'b0};
        for (int i = 0; i < FRAME_CLK; i++) begin
            if (abort_at >= 0 && i == abort_at) return;
            bi = i / BIT_CLK;
            if (bi == DBIT + 1 && !stop_ok) rx = ((i - bi * BIT_CLK) < STOP_LOW) ? 1'b0 : 1'b1;
            else                            rx = bits[bi];
            if (rand_pop) rd_uart = ($urandom_range(0, 7) == 0);
            else          rd_uart = pop_at_stop && (cyc == p);
            cycle();
        end
        rx      = 1'b1;
        rd_uart = 1'b0;
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        rx      = 1'b1;
        rd_uart = 1'b0;
        #1;
        check("reset rx_empty", rx_empty, 1);
        check("reset r_data", r_data, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overrun", overrun, 0);
        q.delete();
        evq.delete();
        repeat (3) cycle();
        reset = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [DBIT-1:0] exp);
        check(name, r_data, exp);
        pop_one();
    endtask

    initial begin
        logic [DBIT-1:0] d;
        bit              ok;

        rand_pop = 1'b0;
        #2;
        apply_reset();
        idle(20);

        // Single frame.
        send_frame(8'h35, 1'b1, 1'b0, -1);
        idle(10);
        check("single not empty", rx_empty, 0);
        pop_expect("single data", 8'h35);
        check("single empty after pop", rx_empty, 1);

        // Burst and order, then a pop while empty.
        for (int i = 1; i <= 3; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, -1);
            idle(4);
        end
        for (int i = 1; i <= 3; i++) pop_expect("burst order", 8'(i));
        pop_one();
        check("pop on empty", rx_empty, 1);
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        idle(6);
        pop_expect("after empty pop", 8'hC3);
        check("after empty pop drained", rx_empty, 1);

        // Overrun.
        ovr_seen = 0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, -1);
            idle(4);
        end
        check("overrun pulse count", ovr_seen, 1);
        for (int i = 1; i <= 4; i++) pop_expect("overrun survivors", 8'(i));
        check("overrun drained", rx_empty, 1);

        // Frame error, then a short glitch on idle rx.
        ferr_seen = 0;
        send_frame(8'hA5, 1'b0, 1'b0, -1);
        idle(30);
        check("frame_err pulse count", ferr_seen, 1);
        check("frame_err no byte", rx_empty, 1);
        rx = 1'b0;
        repeat (20) cycle();
        idle(100);
        check("glitch no error", ferr_seen, 1);
        check("glitch no byte", rx_empty, 1);

        // Push and pop on the same edge while full.
        ovr_seen = 0;
        send_frame(8'h11, 1'b1, 1'b0, -1); idle(4);
        send_frame(8'h22, 1'b1, 1'b0, -1); idle(4);
        send_frame(8'h33, 1'b1, 1'b0, -1); idle(4);
        send_frame(8'h44, 1'b1, 1'b0, -1); idle(4);
        send_frame(8'h55, 1'b1, 1'b1, -1); idle(4);
        check("simultaneous no overrun", ovr_seen, 0);
        check("simultaneous still full", q.size(), DEPTH);
        pop_expect("simultaneous order", 8'h22);
        pop_expect("simultaneous order", 8'h33);
        pop_expect("simultaneous order", 8'h44);
        pop_expect("simultaneous last", 8'h55);
        check("simultaneous drained", rx_empty, 1);

        // Reset in the middle of the data bits.
        send_frame(8'hC6, 1'b1, 1'b0, 4 * BIT_CLK);
        apply_reset();
        idle(10);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        idle(10);
        pop_expect("after reset frame", 8'h7E);
        check("after reset drained", rx_empty, 1);

        // Random traffic with random consumer activity.
        rand_pop = 1'b1;
        for (int f = 0; f < 24; f++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send_frame(d, ok, 1'b0, -1);
            idle($urandom_range(2, 12) + (ok ? 0 : 16));
        end
        rand_pop = 1'b0;
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) pop_one();
        check("random drained", rx_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
